fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling buffer between instruction fetch (PC register + InstrMem) and the Decode stage.
- Captures {pc, instr} pairs from fetch with a valid/ready handshake and stores them in a DEPTH-entry circular FIFO.
- Presents the oldest entry to Decode, together with a registered predecode class and a misalignment flag.
- Flushes atomically on a control-flow redirect, so Decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_WIDTH, 32, PC width; matches `AddrWidth.
- INSTR_WIDTH, 32, instruction width; matches `InstrWidth.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- enq_valid  in  1  fetch presents a valid pair.
- enq_ready  out  1  queue can accept this cycle.
- enq_pc  in  ADDR_WIDTH  PC of the fetched instruction.
- enq_instr  in  INSTR_WIDTH  fetched instruction word.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  Decode consumes the head this cycle.
- deq_pc  out  ADDR_WIDTH  head PC.
- deq_instr  out  INSTR_WIDTH  head instruction.
- deq_kind  out  `KindWidth (3)  predecode class of the head entry.
- deq_misaligned  out  1  head pc[1:0] != 0.
- flush  in  1  redirect: discard all contents.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset==0, asynchronous):
  - head pointer, tail pointer and count = 0.
  - deq_valid = 0; enq_ready = 1.
  - deq_pc, deq_instr, deq_kind, deq_misaligned = 0.
  - Entry storage is not reset. Outputs are gated by count, so stale storage is never observable.
- Enqueue: fires when enq_valid && enq_ready at a rising edge. Writes {enq_pc, enq_instr, kind, misaligned} at tail; tail advances by 1 modulo DEPTH.
- Dequeue: fires when deq_valid && deq_ready at a rising edge. Head advances by 1 modulo DEPTH.
- Handshake readiness:
  - enq_ready = (count < DEPTH). It is combinational from registered count only and never depends on deq_ready, so there is no ready-path loop.
  - deq_valid = (count != 0).
- Latency and bypass:
  - Enqueue-to-deq_valid latency is 1 cycle. There is no same-cycle bypass when empty.
  - When full, no enqueue is accepted even if a dequeue fires in the same cycle.
- Outputs: deq_* are read combinationally from storage[head] and are zero when count == 0.
- Simultaneous enqueue and dequeue (0 < count < DEPTH): both fire; count is unchanged.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; count is tracked separately to tell full from empty.
- Flush (synchronous, highest priority):
  - At the edge where flush==1: head = tail = count = 0.
  - A same-cycle enqueue is dropped and a same-cycle dequeue has no effect.
  - On the cycle after flush, deq_valid = 0.
- Predecode (combinational on enq_instr, stored per entry):
  - opcode = instr[6:0] maps to kind:
    - `KindAlu: OP, OP-IMM, LUI, AUIPC
    - `KindLoad: LOAD
    - `KindStore: STORE
    - `KindBranch: BRANCH
    - `KindJal: JAL
    - `KindJalr: JALR
    - `KindSystem: SYSTEM
    - `KindIllegal: anything else
  - misaligned = |enq_pc[1:0].
- Reset asserted mid-operation clears the queue immediately, independent of clk.

Decomposition:
- Shared constants go in Defines.v:
  - `KindWidth and the `Kind* encodings: Alu=0, Load=1, Store=2, Branch=3, Jal=4, Jalr=5, System=6, Illegal=7.
  - RV32I opcode constants.
- One combinational sub-module, fetch_predecode: instr -> kind. Decode reuses it for assertions.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release -> deq_valid=0, enq_ready=1, count=0, deq_pc=0.
- Fill and drain:
  - Enqueue pc=0x00,0x04,0x08,0x0C with deq_ready=0 -> count=4, enq_ready=0; a 5th enq_valid is ignored.
  - Drain with deq_ready=1 -> pcs emerge in order 0x00..0x0C; then deq_valid=0.
- Streaming and wrap:
  - Enq_valid and deq_ready held at 1 for 20 cycles with pc incrementing by 4, starting at 0x100.
  - After the first fill cycle -> count stays 1, and deq_pc lags enq_pc by one cycle.
  - Pointers wrap past DEPTH with no lost or duplicated entries.
- Flush with concurrent traffic:
  - Count=3, then flush=1 with enq_valid=1 (pc=0x200) and deq_ready=1.
  - Next cycle -> count=0, deq_valid=0; pc 0x200 is never dequeued.
- Predecode and misalignment:
  - Enqueue 0x00000063 (BEQ) -> `KindBranch.
  - Enqueue 0x0000006F (JAL) -> `KindJal.
  - Enqueue 0x00000000 -> `KindIllegal.
  - Enqueue pc=0x102 -> deq_misaligned=1.
- Async reset mid-stream: with count=2, pulse reset=0 between clock edges -> deq_valid and count drop to 0 before the next rising edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: predecode class encodings,
// RV32I major opcodes and a small PC alignment helper.
package fetch_queue_pkg;

  localparam int KIND_WIDTH = 3;

  // Predecode classes presented to Decode alongside each instruction
  localparam logic [KIND_WIDTH-1:0] KIND_ALU     = 3'd0;
  localparam logic [KIND_WIDTH-1:0] KIND_LOAD    = 3'd1;
  localparam logic [KIND_WIDTH-1:0] KIND_STORE   = 3'd2;
  localparam logic [KIND_WIDTH-1:0] KIND_BRANCH  = 3'd3;
  localparam logic [KIND_WIDTH-1:0] KIND_JAL     = 3'd4;
  localparam logic [KIND_WIDTH-1:0] KIND_JALR    = 3'd5;
  localparam logic [KIND_WIDTH-1:0] KIND_SYSTEM  = 3'd6;
  localparam logic [KIND_WIDTH-1:0] KIND_ILLEGAL = 3'd7;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // A fetch PC is misaligned when it is not on a 4-byte boundary
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return |pc_lsb;
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode: classifies an instruction word by its major opcode.
// Also reused by Decode for its own consistency assertions.
module fetch_predecode
  import fetch_queue_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [KIND_WIDTH-1:0]  kind
);

  // Only the major opcode matters for classification
  logic w_unused_upper;
  assign w_unused_upper = ^instr[INSTR_WIDTH-1:7];

  // Opcode to class lookup; anything unrecognised is flagged illegal
  always_comb begin
    kind = KIND_ILLEGAL;
    case (instr[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: kind = KIND_ALU;
      OPC_LOAD:   kind = KIND_LOAD;
      OPC_STORE:  kind = KIND_STORE;
      OPC_BRANCH: kind = KIND_BRANCH;
      OPC_JAL:    kind = KIND_JAL;
      OPC_JALR:   kind = KIND_JALR;
      OPC_SYSTEM: kind = KIND_SYSTEM;
      default:    kind = KIND_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr, kind, misaligned} between fetch and Decode.
// Occupancy is tracked separately from the pointers to tell full from empty;
// a redirect flush empties the queue atomically.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [ADDR_WIDTH-1:0]  enq_pc,
  input  logic [INSTR_WIDTH-1:0] enq_instr,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [ADDR_WIDTH-1:0]  deq_pc,
  output logic [INSTR_WIDTH-1:0] deq_instr,
  output logic [KIND_WIDTH-1:0]  deq_kind,
  output logic                   deq_misaligned,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Entry storage (not reset: reads are gated by occupancy)
  logic [ADDR_WIDTH-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [KIND_WIDTH-1:0]  r_kind_mem  [DEPTH];
  logic                   r_mis_mem   [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic                  w_enq_fire;
  logic                  w_deq_fire;
  logic [KIND_WIDTH-1:0] w_enq_kind;
  logic                  w_enq_mis;

  fetch_predecode #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_predecode (
    .instr (enq_instr),
    .kind  (w_enq_kind)
  );

  assign w_enq_mis = pc_misaligned(enq_pc[1:0]);

  // Readiness depends only on registered occupancy, never on deq_ready
  assign enq_ready = (r_count < FULL_COUNT);
  assign deq_valid = (r_count != '0);
  assign count     = r_count;

  // Flush overrides both handshakes in the cycle it is asserted
  assign w_enq_fire = enq_valid && enq_ready && !flush;
  assign w_deq_fire = deq_valid && deq_ready && !flush;

  // Write the predecoded entry at the tail on an accepted enqueue
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_pc_mem[r_tail]    <= enq_pc;
      r_instr_mem[r_tail] <= enq_instr;
      r_kind_mem[r_tail]  <= w_enq_kind;
      r_mis_mem[r_tail]   <= w_enq_mis;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) r_tail <= r_tail + PTR_W'(1);
      if (w_deq_fire) r_head <= r_head + PTR_W'(1);
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Present the head entry, forced to zero while the queue is empty
  always_comb begin
    deq_pc         = '0;
    deq_instr      = '0;
    deq_kind       = '0;
    deq_misaligned = 1'b0;
    if (deq_valid) begin
      deq_pc         = r_pc_mem[r_head];
      deq_instr      = r_instr_mem[r_head];
      deq_kind       = r_kind_mem[r_head];
      deq_misaligned = r_mis_mem[r_head];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  deq_kind;
  logic        deq_misaligned;
  logic        flush;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_pc         (enq_pc),
    .enq_instr      (enq_instr),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr),
    .deq_kind       (deq_kind),
    .deq_misaligned (deq_misaligned),
    .flush          (flush),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t model_q[$];

  function automatic logic [2:0] model_kind(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17) return 3'd0;
    if (op == 7'h03) return 3'd1;
    if (op == 7'h23) return 3'd2;
    if (op == 7'h63) return 3'd3;
    if (op == 7'h6F) return 3'd4;
    if (op == 7'h67) return 3'd5;
    if (op == 7'h73) return 3'd6;
    return 3'd7;
  endfunction

  // Queue semantics: flush empties, full blocks enqueue even with a dequeue
  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      model_q.delete();
    end else begin
      bit do_enq;
      bit do_deq;
      ent_t e;
      do_enq = enq_valid && (model_q.size() < DEPTH);
      do_deq = deq_ready && (model_q.size() != 0);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) begin
        e.pc    = enq_pc;
        e.instr = enq_instr;
        model_q.push_back(e);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [2:0]  e_kind;
    logic        e_mis;
    e_pc = 0; e_ins = 0; e_kind = 0; e_mis = 0;
    if (model_q.size() != 0) begin
      e_pc   = model_q[0].pc;
      e_ins  = model_q[0].instr;
      e_kind = model_kind(model_q[0].instr);
      e_mis  = (model_q[0].pc[1:0] != 2'b00);
    end
    chk("model_count", 64'(count), 64'(model_q.size()));
    chk("model_enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
    chk("model_deq_valid", 64'(deq_valid), 64'(model_q.size() != 0));
    chk("model_deq_pc", 64'(deq_pc), 64'(e_pc));
    chk("model_deq_instr", 64'(deq_instr), 64'(e_ins));
    chk("model_deq_kind", 64'(deq_kind), 64'(e_kind));
    chk("model_deq_mis", 64'(deq_misaligned), 64'(e_mis));
  end

  // Apply one cycle of inputs; return just after the following falling edge
  task automatic cyc(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                     input logic dr, input logic fl);
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = ins;
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    enq_valid = 1'b0;
    enq_pc    = '0;
    enq_instr = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    // Reset then idle
    cyc(0, 0, 0, 0, 0);
    chk("rst_deq_valid", 64'(deq_valid), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);
    chk("rst_count", 64'(count), 0);
    chk("rst_deq_pc", 64'(deq_pc), 0);

    // Fill to capacity, then a fifth offer is refused
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'h13, 0, 0);
    chk("fill_count", 64'(count), 4);
    chk("fill_enq_ready", 64'(enq_ready), 0);
    cyc(1, 32'h10, 32'h13, 0, 0);
    chk("fill_5th_ignored", 64'(count), 4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(deq_pc), 64'(i * 4));
      cyc(0, 0, 0, 1, 0);
    end
    chk("drain_empty", 64'(deq_valid), 0);

    // Streaming with wrap: occupancy stays at one, head lags tail by a cycle
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h100 + 32'(i * 4), 32'h13, 1, 0);
      chk("stream_count", 64'(count), 1);
      chk("stream_pc", 64'(deq_pc), 64'(32'h100 + 32'(i * 4)));
    end
    cyc(0, 0, 0, 1, 0);
    chk("stream_drained", 64'(count), 0);

    // Flush with concurrent enqueue and dequeue
    for (int i = 0; i < 3; i++) cyc(1, 32'h1F0 + 32'(i * 4), 32'h33, 0, 0);
    chk("pre_flush_count", 64'(count), 3);
    cyc(1, 32'h200, 32'h13, 1, 1);
    chk("flush_count", 64'(count), 0);
    chk("flush_deq_valid", 64'(deq_valid), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("flush_no_wrongpath", 64'(deq_valid), 0);

    // Predecode classes and misalignment
    cyc(1, 32'h300, 32'h00000063, 0, 0);
    cyc(1, 32'h304, 32'h0000006F, 0, 0);
    cyc(1, 32'h308, 32'h00000000, 0, 0);
    cyc(1, 32'h102, 32'h00000013, 0, 0);
    chk("pd_beq_kind", 64'(deq_kind), 3);
    cyc(0, 0, 0, 1, 0);
    chk("pd_jal_kind", 64'(deq_kind), 4);
    cyc(0, 0, 0, 1, 0);
    chk("pd_zero_kind", 64'(deq_kind), 7);
    cyc(0, 0, 0, 1, 0);
    chk("pd_mis_pc", 64'(deq_pc), 64'h102);
    chk("pd_misaligned", 64'(deq_misaligned), 1);
    chk("pd_addi_kind", 64'(deq_kind), 0);
    cyc(0, 0, 0, 1, 0);

    // Asynchronous reset between clock edges
    cyc(1, 32'h400, 32'h13, 0, 0);
    cyc(1, 32'h404, 32'h13, 0, 0);
    enq_valid = 1'b0;
    chk("pre_areset_count", 64'(count), 2);
    #1 reset = 1'b0;
    #1;
    chk("areset_count", 64'(count), 0);
    chk("areset_deq_valid", 64'(deq_valid), 0);
    chk("areset_enq_ready", 64'(enq_ready), 1);
    #1 reset = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      logic [31:0] pc;
      logic [6:0]  opc;
      logic [6:0]  opcs [10];
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73};
      r   = $urandom();
      opc = ($urandom_range(9) == 0) ? r[6:0] : opcs[$urandom_range(9)];
      pc  = $urandom() & 32'h0000FFFF;
      if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
      cyc($urandom_range(99) < 70, pc, {r[31:7], opc},
          $urandom_range(99) < 55, $urandom_range(99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
